plic_tl_arbiter: RTL and testbench



---
 rtl/plic_tl_arbiter_pkg.sv | 80 ++++++++
 rtl/plic_tl_arbiter_if.sv | 29 ++
 rtl/plic_tl_arbiter_rr_arb2.sv | 38 +++
 rtl/plic_tl_arbiter.sv | 80 ++++++++
 tb/tb_plic_tl_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_tl_arbiter_pkg.sv
// TileLink-UL types shared by the PLIC two-master arbiter and its bench.
// Slave-side source IDs carry one extra MSB holding the master index.
package tl_arb_pkg;

    localparam int TL_RS = 4;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [1:0]       size;
        logic [TL_RS-1:0] source;
        logic [21:0]      address;
        logic [3:0]       mask;
        logic [31:0]      data;
        logic             corrupt;
    } tl_a_m_t;

    typedef struct packed {
        logic [2:0]     opcode;
        logic [2:0]     param;
        logic [1:0]     size;
        logic [TL_RS:0] source;
        logic [21:0]    address;
        logic [3:0]     mask;
        logic [31:0]    data;
        logic           corrupt;
    } tl_a_s_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [1:0]       param;
        logic [1:0]       size;
        logic [TL_RS-1:0] source;
        logic             denied;
        logic [31:0]      data;
        logic             corrupt;
    } tl_d_m_t;

    typedef struct packed {
        logic [2:0]     opcode;
        logic [1:0]     param;
        logic [1:0]     size;
        logic [TL_RS:0] source;
        logic           denied;
        logic [31:0]    data;
        logic           corrupt;
    } tl_d_s_t;

    function automatic tl_a_s_t a_to_slave(input tl_a_m_t a, input logic idx);
        tl_a_s_t s;
        s.opcode  = a.opcode;
        s.param   = a.param;
        s.size    = a.size;
        s.source  = {idx, a.source};
        s.address = a.address;
        s.mask    = a.mask;
        s.data    = a.data;
        s.corrupt = a.corrupt;
        return s;
    endfunction

    function automatic tl_d_m_t d_to_master(input tl_d_s_t d);
        tl_d_m_t m;
        m.opcode  = d.opcode;
        m.param   = d.param;
        m.size    = d.size;
        m.source  = d.source[TL_RS-1:0];
        m.denied  = d.denied;
        m.data    = d.data;
        m.corrupt = d.corrupt;
        return m;
    endfunction

endpackage

// File: rtl/plic_tl_arbiter_if.sv
// TileLink-UL link bundles: tl_m_if carries master-width source IDs,
// tl_s_if carries the widened slave-side IDs.
interface tl_m_if;
    import tl_arb_pkg::*;

    tl_a_m_t a_bits;
    logic    a_valid;
    logic    a_ready;
    tl_d_m_t d_bits;
    logic    d_valid;
    logic    d_ready;

    modport master (output a_bits, a_valid, d_ready, input a_ready, d_bits, d_valid);
    modport slave  (input a_bits, a_valid, d_ready, output a_ready, d_bits, d_valid);
endinterface

interface tl_s_if;
    import tl_arb_pkg::*;

    tl_a_s_t a_bits;
    logic    a_valid;
    logic    a_ready;
    tl_d_s_t d_bits;
    logic    d_valid;
    logic    d_ready;

    modport master (output a_bits, a_valid, d_ready, input a_ready, d_bits, d_valid);
    modport slave  (input a_bits, a_valid, d_ready, output a_ready, d_bits, d_valid);
endinterface

// File: rtl/plic_tl_arbiter_rr_arb2.sv
// Two-way grant logic. PLIC_TL_ARB_RR_EN selects round-robin; otherwise
// master 0 has fixed priority and last_grant is kept but not consulted.
module tl_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        // NOTE: gnt gets a default before any branch so no path can infer a latch.
        gnt = 2'b00;
        if (take) begin
`ifdef PLIC_TL_ARB_RR_EN
            if (&elig) gnt = last_grant ? 2'b01 : 2'b10;
            else       gnt = elig;
`else
            gnt = {elig[1] & ~elig[0], elig[0]};
`endif
        end
    end

    // Reset value 1 lets master 0 win the first contested round-robin slot.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst)       last_grant <= 1'b1;
        else if (|gnt) last_grant <= gnt[1];
    end

`ifndef PLIC_TL_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/plic_tl_arbiter.sv
// Two-master TileLink-UL arbiter in front of the PLIC slave port with a registered
// A stage and per-master outstanding limits. Option macro: PLIC_TL_ARB_RR_EN.
module plic_tl_arbiter
    import tl_arb_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input logic   arb_clock_i,
    input logic   arb_reset_i,
    tl_m_if.slave m0,
    tl_m_if.slave m1,
    tl_s_if.master s
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [CW-1:0] out_cnt [2];
    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic [1:0]    cnt_dec;
    logic          loadable;
    logic          stage_vld;
    tl_a_s_t       stage;
    logic          d_idx;
    logic          d_fire;
    tl_d_m_t       d_m;

    assign loadable = !stage_vld || s.a_ready;
    assign elig     = {m1.a_valid && (out_cnt[1] < CNT_MAX),
                       m0.a_valid && (out_cnt[0] < CNT_MAX)};

    tl_rr_arb2 u_arb (
        .clk  (arb_clock_i),
        .rst  (arb_reset_i),
        .elig (elig),
        .take (loadable),
        .gnt  (gnt)
    );

    assign m0.a_ready = gnt[0];
    assign m1.a_ready = gnt[1];

    always_ff @(posedge arb_clock_i) begin
        if (arb_reset_i)   stage_vld <= 1'b0;
        else if (loadable) stage_vld <= |gnt;
    end

    // NOTE: the payload register has no reset; stage_vld alone qualifies it.
    always_ff @(posedge arb_clock_i) begin
        if (loadable && |gnt)
            stage <= gnt[1] ? a_to_slave(m1.a_bits, 1'b1) : a_to_slave(m0.a_bits, 1'b0);
    end

    assign s.a_valid = stage_vld;
    assign s.a_bits  = stage;

    // D responses return by the index bit the A stage prepended to the source.
    assign d_idx      = s.d_bits.source[TL_RS];
    assign d_m        = d_to_master(s.d_bits);
    assign m0.d_bits  = d_m;
    assign m1.d_bits  = d_m;
    assign m0.d_valid = s.d_valid && !d_idx;
    assign m1.d_valid = s.d_valid && d_idx;
    assign s.d_ready  = d_idx ? m1.d_ready : m0.d_ready;
    assign d_fire     = s.d_valid && s.d_ready;

    // A response with no outstanding request is a protocol error; the count holds at zero.
    assign cnt_dec[0] = d_fire && !d_idx && (out_cnt[0] != '0);
    assign cnt_dec[1] = d_fire && d_idx  && (out_cnt[1] != '0);

    always_ff @(posedge arb_clock_i) begin
        for (int n = 0; n < 2; n++) begin
            if (arb_reset_i)                 out_cnt[n] <= '0;
            else if (gnt[n] && !cnt_dec[n])  out_cnt[n] <= out_cnt[n] + CW'(1);
            else if (!gnt[n] && cnt_dec[n])  out_cnt[n] <= out_cnt[n] - CW'(1);
        end
    end

endmodule

// File: tb/tb_plic_tl_arbiter.sv
// Randomized scoreboard bench for plic_tl_arbiter with a transaction-level
// reference model of grants, outstanding counts and response routing.
module tb_plic_tl_arbiter;
    import tl_arb_pkg::*;

    localparam int MAX_OUT = 4;

    typedef struct {
        logic [4:0]  src;
        logic [2:0]  op;
        logic [1:0]  param;
        logic [1:0]  size;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl_m_if m0_if ();
    tl_m_if m1_if ();
    tl_s_if s_if ();

    plic_tl_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .arb_clock_i (clk),
        .arb_reset_i (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    int      cnt [2];
    bit      full;
    int      last;
    bit      d_hs;
    tl_a_s_t exp_a [$];
    rsp_t    pend  [$];

    // Stimulus knobs (percent probabilities)
    int p_m0, p_m1, p_sr, p_dr, p_d;
    bit fix_bits;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tl_a_s_t mk_a(input tl_a_m_t a, input logic idx);
        tl_a_s_t r;
        r.opcode  = a.opcode;
        r.param   = a.param;
        r.size    = a.size;
        r.source  = {idx, a.source};
        r.address = a.address;
        r.mask    = a.mask;
        r.data    = a.data;
        r.corrupt = a.corrupt;
        return r;
    endfunction

    function automatic tl_a_m_t rnd_a();
        tl_a_m_t a;
        case ($urandom_range(2))
            0:       a.opcode = PUT_FULL;
            1:       a.opcode = PUT_PARTIAL;
            default: a.opcode = GET;
        endcase
        a.param   = 3'($urandom);
        a.size    = 2'($urandom);
        a.source  = 4'($urandom);
        a.address = 22'($urandom);
        a.mask    = 4'($urandom);
        a.data    = $urandom;
        a.corrupt = 1'($urandom);
        return a;
    endfunction

    function automatic rsp_t mk_rsp(input tl_a_s_t a);
        rsp_t r;
        r.src     = a.source;
        r.op      = (a.opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
        r.param   = 2'($urandom);
        r.size    = a.size;
        r.denied  = 1'($urandom);
        r.data    = $urandom;
        r.corrupt = 1'($urandom);
        return r;
    endfunction

    function automatic tl_d_m_t exp_d(input rsp_t r);
        tl_d_m_t d;
        d.opcode  = r.op;
        d.param   = r.param;
        d.size    = r.size;
        d.source  = r.src[3:0];
        d.denied  = r.denied;
        d.data    = r.data;
        d.corrupt = r.corrupt;
        return d;
    endfunction

    task automatic drive_d(input rsp_t r);
        s_if.d_bits.opcode  = r.op;
        s_if.d_bits.param   = r.param;
        s_if.d_bits.size    = r.size;
        s_if.d_bits.source  = r.src;
        s_if.d_bits.denied  = r.denied;
        s_if.d_bits.data    = r.data;
        s_if.d_bits.corrupt = r.corrupt;
        s_if.d_valid        = 1'b1;
    endtask

    // One clock of stimulus, applied just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (s_if.d_valid && d_hs) begin
            void'(pend.pop_front());
            s_if.d_valid = 1'b0;
        end
        if (!s_if.d_valid && pend.size() > 0 && $urandom_range(99) < p_d) drive_d(pend[0]);
        m0_if.a_valid = ($urandom_range(99) < p_m0);
        m1_if.a_valid = ($urandom_range(99) < p_m1);
        if (!fix_bits) begin
            m0_if.a_bits = rnd_a();
            m1_if.a_bits = rnd_a();
        end
        s_if.a_ready  = ($urandom_range(99) < p_sr);
        m0_if.d_ready = ($urandom_range(99) < p_dr);
        m1_if.d_ready = ($urandom_range(99) < p_dr);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        p_m0 = 0; p_m1 = 0; p_sr = 0; p_d = 0;
        m0_if.a_valid = 1'b0;
        m1_if.a_valid = 1'b0;
        s_if.a_ready  = 1'b0;
        s_if.d_valid  = 1'b0;
        pend.delete();
        step();
        rst = 1'b0;
    endtask

    // Reference model: predicts readies and s_a_valid, queues expected slave requests.
    always @(negedge clk) begin : model
        int      w;
        bit      ld;
        bit [1:0] el;
        int      di;
        ld    = !full || s_if.a_ready;
        el[0] = m0_if.a_valid && (cnt[0] < MAX_OUT);
        el[1] = m1_if.a_valid && (cnt[1] < MAX_OUT);
        w = -1;
        if (ld) begin
            if (el == 2'b11) begin
`ifdef PLIC_TL_ARB_RR_EN
                w = (last == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else if (el[0]) w = 0;
            else if (el[1]) w = 1;
        end
        check("s_a_valid", s_if.a_valid, full);
        check("m0_a_ready", m0_if.a_ready, w == 0);
        check("m1_a_ready", m1_if.a_ready, w == 1);
        d_hs = s_if.d_valid && s_if.d_ready;
        if (rst) begin
            cnt[0] = 0; cnt[1] = 0;
            full = 1'b0;
            last = 1;
            exp_a.delete();
        end else begin
            if (w >= 0) begin
                exp_a.push_back(mk_a(w == 1 ? m1_if.a_bits : m0_if.a_bits, w[0]));
                cnt[w]++;
                last = w;
            end
            if (d_hs && pend.size() > 0) begin
                di = int'(pend[0].src[4]);
                if (cnt[di] > 0) cnt[di]--;
            end
            if (ld) full = (w >= 0);
        end
    end

    // A-channel monitor: compares each slave handshake against the scoreboard.
    always @(negedge clk) begin : a_mon
        tl_a_s_t e;
        tl_a_s_t held;
        bit      held_v;
        if (!rst && s_if.a_valid && s_if.a_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_a_unexpected: got %0h expected none", s_if.a_bits);
            end else begin
                e = exp_a.pop_front();
                check("s_a_bits", s_if.a_bits, e);
                pend.push_back(mk_rsp(e));
            end
        end
        if (!rst && s_if.a_valid && !s_if.a_ready) begin
            if (held_v) check("s_a_hold", s_if.a_bits, held);
            held   = s_if.a_bits;
            held_v = 1'b1;
        end else begin
            held_v = 1'b0;
        end
    end

    // D-channel monitor: routing, back-pressure and payload per response.
    always @(negedge clk) begin : d_mon
        rsp_t r;
        logic idx;
        if (!rst) begin
            if (s_if.d_valid && pend.size() > 0) begin
                r   = pend[0];
                idx = r.src[4];
                check("m0_d_valid", m0_if.d_valid, !idx);
                check("m1_d_valid", m1_if.d_valid, idx);
                check("s_d_ready", s_if.d_ready, idx ? m1_if.d_ready : m0_if.d_ready);
                if (s_if.d_ready) check("m_d_bits", idx ? m1_if.d_bits : m0_if.d_bits, exp_d(r));
            end else if (!s_if.d_valid) begin
                check("m0_d_idle", m0_if.d_valid, 1'b0);
                check("m1_d_idle", m1_if.d_valid, 1'b0);
            end
        end
    end

    initial begin
        p_m0 = 0; p_m1 = 0; p_sr = 0; p_dr = 0; p_d = 0;
        fix_bits = 1'b0;
        cnt[0] = 0; cnt[1] = 0; full = 1'b0; last = 1; d_hs = 1'b0;
        m0_if.a_valid = 1'b0; m0_if.a_bits = '0; m0_if.d_ready = 1'b0;
        m1_if.a_valid = 1'b0; m1_if.a_bits = '0; m1_if.d_ready = 1'b0;
        s_if.a_ready  = 1'b0; s_if.d_valid = 1'b0; s_if.d_bits = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Directed Get from master 0
        fix_bits = 1'b1;
        m0_if.a_bits = '{opcode: GET, param: 3'd0, size: 2'd2, source: 4'd3,
                         address: 22'h200004, mask: 4'hf, data: 32'd0, corrupt: 1'b0};
        p_m0 = 100; p_sr = 100; p_dr = 100;
        step();
        p_m0 = 0;
        step();
        @(negedge clk);
        check("get_source", s_if.a_bits.source, 5'h03);
        check("get_address", s_if.a_bits.address, 22'h200004);
        p_d = 100;
        repeat (4) step();
        fix_bits = 1'b0;

        // Both masters contending at full throughput
        p_m0 = 100; p_m1 = 100; p_sr = 100; p_dr = 100; p_d = 100;
        repeat (20) step();

        // Slave stall with the stage full, then release
        p_sr = 0;
        repeat (6) step();
        p_sr = 100;
        repeat (3) step();

        // Outstanding limit: withhold D, fill master 0, then master 1 still proceeds
        p_m0 = 0; p_m1 = 0;
        repeat (15) step();
        p_d = 0; p_m0 = 100;
        repeat (7) step();
        p_m1 = 100;
        repeat (3) step();
        p_m1 = 0; p_d = 100;
        repeat (6) step();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            p_m0 = $urandom_range(100);
            p_m1 = $urandom_range(100);
            p_sr = $urandom_range(100);
            p_dr = $urandom_range(100);
            p_d  = $urandom_range(100);
            repeat (50) step();
        end

        // Reset with the stage full and requests outstanding
        p_m0 = 100; p_m1 = 100; p_sr = 100; p_dr = 100; p_d = 0;
        repeat (4) step();
        p_sr = 0;
        step();
        do_reset();
        p_m0 = 100; p_m1 = 100; p_sr = 100; p_dr = 100; p_d = 100;
        step();
        @(negedge clk);
        check("first_grant_m0", m0_if.a_ready, 1'b1);
        check("first_grant_m1", m1_if.a_ready, 1'b0);
        repeat (20) step();

        // Drain everything
        p_m0 = 0; p_m1 = 0; p_sr = 100; p_dr = 100; p_d = 100;
        repeat (60) step();
        @(negedge clk);
        check("drain_a", exp_a.size(), 0);
        check("drain_d", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
